// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a BOOT/RUN/FAULT
// control FSM handling redirect, flush, stall and shared-memory contention.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        mem_busy,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        fault
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned IADDR_W = 6;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc_next, ifid_pc_next, ifid_instr_next;
  logic              ifid_valid_next, fault_next;
  logic              bubble;

  // Word address into the 64-entry instruction memory; upper PC bits are ignored.
  assign imem_addr = pc[IADDR_W+1:2];

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
      ifid_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ifid_pc    <= ifid_pc_next;
      ifid_instr <= ifid_instr_next;
      ifid_valid <= ifid_valid_next;
      fault      <= fault_next;
    end
  end

  // Next-state logic; events in RUN are prioritised redirect > flush > stall > mem_busy.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ifid_pc_next    = ifid_pc;
    ifid_instr_next = ifid_instr;
    ifid_valid_next = ifid_valid;
    bubble          = 1'b0;

    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect_valid) begin
          bubble = 1'b1;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_next = redirect_pc;
          end else begin
            state_next = FAULT;
          end
        end else if (flush) begin
          bubble = 1'b1;
        end else if (stall) begin
          bubble = 1'b0;
        end else if (mem_busy) begin
          bubble = 1'b1;
        end else begin
          ifid_instr_next = imem_data;
          ifid_pc_next    = pc;
          ifid_valid_next = 1'b1;
          pc_next         = pc + XLEN'(4);
        end
      end
      FAULT: bubble = 1'b1;
      default: begin
        state_next = BOOT;
        bubble     = 1'b1;
      end
    endcase

    if (bubble) begin
      ifid_valid_next = 1'b0;
      ifid_instr_next = NOP_INSTR;
      ifid_pc_next    = '0;
    end

    fault_next = (state_next == FAULT);
  end

endmodule
